gcd_dispatch: RTL and testbench
===============================

GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter: TIMEOUT, 1024, maximum clk cycles spent in WAIT before the job is aborted; legal range 2..65535.
REQ-002 Parameter: START_HOLD, 2, number of clk cycles eng_start is held high per launch; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  upstream operand pair valid.
REQ-006 req_ready  output  1  dispatcher can accept an operand pair.
REQ-007 req_a, req_b  input  32 each  unsigned operands.
REQ-008 eng_a, eng_b  output  32 each  operands driven to the GCD engine.
REQ-009 eng_start  output  1  engine load/start strobe.
REQ-010 eng_done  input  1  engine result valid, level or pulse.
REQ-011 eng_result  input  32  engine result.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  downstream accepts response.
REQ-014 rsp_result  output  32  GCD result; 0 on error.
REQ-015 rsp_err  output  1  job aborted on timeout.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LAUNCH, WAIT and RESP.
REQ-018 req_ready SHALL equal (state==IDLE); a request SHALL be accepted on the cycle req_valid&&req_ready is true, and only one job SHALL be in flight.
REQ-019 On accept, req_a and req_b SHALL be captured into eng_a and eng_b, which SHALL remain stable until the next accept.
REQ-020 Zero bypass: if either operand is 0 at accept, the FSM SHALL go directly to RESP with rsp_result=req_a|req_b and rsp_err=0, rsp_valid SHALL be high the next cycle, and eng_start SHALL never assert.
REQ-021 Otherwise the FSM SHALL enter LAUNCH, and eng_start SHALL be high for exactly START_HOLD consecutive cycles beginning the cycle after accept.
REQ-022 eng_done SHALL be ignored in IDLE, LAUNCH and RESP, which masks stale done from the previous job.
REQ-023 After the last eng_start cycle, the FSM SHALL enter WAIT and clear a 16-bit wait counter.
REQ-024 In WAIT, the first cycle with eng_done=1 SHALL capture eng_result into rsp_result, set rsp_err=0 and move to RESP; rsp_valid SHALL be high the following cycle.
REQ-025 In WAIT without eng_done, the counter SHALL increment each cycle.
REQ-026 When the counter reaches TIMEOUT-1 without done, the FSM SHALL move to RESP with rsp_result=0 and rsp_err=1.
REQ-027 If eng_done arrives on the same cycle the counter reaches TIMEOUT-1, done SHALL win (rsp_err=0).
REQ-028 rsp_valid SHALL equal (state==RESP).
REQ-029 rsp_result and rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-030 On rsp_valid&&rsp_ready the FSM SHALL return to IDLE, and req_ready SHALL rise the next cycle; there is no response/request overlap.
REQ-031 After a timeout, the next job SHALL relaunch the engine normally; the engine reload via eng_start discards the aborted computation.
REQ-032 All outputs SHALL be registered except req_ready, rsp_valid and busy, which are decoded from registered state.

Reset
REQ-033 Asserting reset_n=0 SHALL asynchronously force state=IDLE; eng_a, eng_b, rsp_result and the wait counter to 0; and eng_start, rsp_valid, rsp_err and busy to 0; req_ready SHALL be 1 while reset is deasserted in IDLE.
REQ-034 Reset mid-LAUNCH or mid-WAIT SHALL abandon the job with no response emitted.
REQ-035 The first accept after deassertion SHALL behave as from a cold IDLE.

Verification
REQ-036 Reset: hold reset_n=0 -> all outputs 0 and busy=0; after release, req_ready=1.
REQ-037 Normal job: a=48, b=18; engine model asserts done 10 cycles after the start falls with result 6 -> eng_start high exactly 2 cycles; rsp_result=6, rsp_err=0; rsp_valid high one cycle after done.
REQ-038 Zero bypass: a=0, b=35 -> rsp_valid the next cycle, rsp_result=35, eng_start never high; also a=0, b=0 -> rsp_result=0, rsp_err=0.
REQ-039 Timeout: TIMEOUT=16, done held low -> rsp_err=1 and rsp_result=0, with RESP entered 16 cycles after WAIT entry; a following job a=21, b=14 -> 7 with rsp_err=0.
REQ-040 Backpressure and stale done: rsp_ready=0 for 5 cycles -> response stable and req_ready=0; done left high from the previous job during LAUNCH -> not captured.
REQ-041 Reset mid-WAIT: pulse reset_n low -> no rsp_valid, state IDLE; a new job a=9, b=6 -> 3.

Source files
------------

// File: rtl/gcd_dispatch.sv
// Dispatches one operand pair at a time to an external GCD engine; zero operands bypass the engine, and a stalled engine times out with an error response.
// Latency: a bypassed job responds the cycle after accept. While a response waits for rsp_ready, both the request and response sides are stalled.
module gcd_dispatch #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned START_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic [31:0] eng_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  HOLD_LAST = 4'(START_HOLD - 1);

    state_t      state, state_nxt;
    logic [31:0] eng_a_nxt, eng_b_nxt, rsp_result_nxt;
    logic        eng_start_nxt, rsp_err_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [3:0]  hold_cnt, hold_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            eng_a      <= '0;
            eng_b      <= '0;
            eng_start  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            eng_a      <= eng_a_nxt;
            eng_b      <= eng_b_nxt;
            eng_start  <= eng_start_nxt;
            rsp_result <= rsp_result_nxt;
            rsp_err    <= rsp_err_nxt;
            wait_cnt   <= wait_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        eng_a_nxt      = eng_a;
        eng_b_nxt      = eng_b;
        eng_start_nxt  = eng_start;
        rsp_result_nxt = rsp_result;
        rsp_err_nxt    = rsp_err;
        wait_cnt_nxt   = wait_cnt;
        hold_cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    eng_a_nxt = req_a;
                    eng_b_nxt = req_b;
                    if (req_a == 32'd0 || req_b == 32'd0) begin
                        state_nxt      = RESP;
                        rsp_result_nxt = req_a | req_b;
                        rsp_err_nxt    = 1'b0;
                    end else begin
                        state_nxt     = LAUNCH;
                        eng_start_nxt = 1'b1;
                        hold_cnt_nxt  = HOLD_LAST;
                    end
                end
            end
            LAUNCH: begin
                if (hold_cnt == 4'd0) begin
                    state_nxt     = WAIT;
                    eng_start_nxt = 1'b0;
                    wait_cnt_nxt  = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
            WAIT: begin
                // done is checked first so a completion on the last counted cycle still wins
                if (eng_done) begin
                    state_nxt      = RESP;
                    rsp_result_nxt = eng_result;
                    rsp_err_nxt    = 1'b0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt      = RESP;
                    rsp_result_nxt = '0;
                    rsp_err_nxt    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed and randomized jobs against a cycle-level reference of the dispatcher, with the GCD engine modelled in the bench.
module tb_gcd_dispatch;

    localparam int TIMEOUT    = 16;
    localparam int START_HOLD = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b, eng_a, eng_b, eng_result, rsp_result;
    logic        eng_start, eng_done, rsp_valid, rsp_ready, rsp_err, busy;

    int n_cmp = 0;
    int n_err = 0;

    gcd_dispatch #(.TIMEOUT(TIMEOUT), .START_HOLD(START_HOLD)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
        .eng_done(eng_done), .eng_result(eng_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gcd(input logic [31:0] x0, input logic [31:0] y0);
        logic [31:0] x, y, t;
        x = x0;
        y = y0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delay: WAIT cycle index (0 = first cycle after start falls) on which done pulses; >= TIMEOUT means never
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int delay,
                           input int bp, input bit stale);
        logic [31:0] exp_res;
        logic        exp_err;
        int          last;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        if (stale) eng_done = 1'b1;
        step();
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        check("eng_a_capture", eng_a, a);
        check("eng_b_capture", eng_b, b);
        if (a == 0 || b == 0) begin
            eng_done = 1'b0;
            exp_res  = a | b;
            exp_err  = 1'b0;
        end else begin
            for (int i = 0; i < START_HOLD; i++) begin
                check("start_high", {31'd0, eng_start}, 32'd1);
                check("launch_no_rsp", {31'd0, rsp_valid}, 32'd0);
                check("launch_busy", {30'd0, busy, req_ready}, 32'd2);
                step();
            end
            last = (delay < TIMEOUT) ? delay : TIMEOUT - 1;
            for (int d = 0; d <= last; d++) begin
                check("wait_start_low", {31'd0, eng_start}, 32'd0);
                check("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
                eng_done   = (d == delay);
                eng_result = (d == delay) ? gcd(a, b) : $urandom;
                step();
            end
            eng_done = 1'b0;
            exp_res  = (delay < TIMEOUT) ? gcd(a, b) : 32'd0;
            exp_err  = (delay >= TIMEOUT);
        end
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_busy", {30'd0, busy, req_ready}, 32'd2);
        check("rsp_no_start", {31'd0, eng_start}, 32'd0);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        for (int k = 0; k < bp; k++) begin
            rsp_ready = 1'b0;
            eng_done  = 1'b1;
            eng_result = $urandom;
            step();
            check("bp_valid", {30'd0, rsp_valid, req_ready}, 32'd2);
            check("bp_result", rsp_result, exp_res);
            check("bp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check("bp_eng_a", eng_a, a);
        end
        eng_done  = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("post_rsp", {29'd0, rsp_valid, req_ready, busy}, 32'd2);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        rsp_ready  = 1'b0;
        step();
        step();
        check("rst_eng_a", eng_a, 32'd0);
        check("rst_eng_b", eng_b, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", {29'd0, eng_start, rsp_valid, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        run_job(32'd48, 32'd18, 10, 0, 1'b0);
        run_job(32'd0, 32'd35, 0, 0, 1'b0);
        run_job(32'd0, 32'd0, 0, 1, 1'b0);
        run_job(32'd100, 32'd75, 1000, 0, 1'b0);
        run_job(32'd21, 32'd14, 4, 0, 1'b0);
        run_job(32'd12, 32'd8, 3, 5, 1'b0);
        run_job(32'd30, 32'd45, 6, 0, 1'b1);
        run_job(32'd27, 32'd18, TIMEOUT - 1, 2, 1'b0);
        run_job(32'd77, 32'd0, 0, 0, 1'b1);

        // reset while waiting on the engine
        req_valid = 1'b1;
        req_a     = 32'd50;
        req_b     = 32'd30;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < START_HOLD + 3; i++) step();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_outputs", {28'd0, eng_start, rsp_valid, rsp_err, busy}, 32'd0);
        check("midrst_eng_a", eng_a, 32'd0);
        check("midrst_result", rsp_result, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("midrst_idle", {29'd0, rsp_valid, req_ready, busy}, 32'd2);
        run_job(32'd9, 32'd6, 3, 0, 1'b0);

        for (int j = 0; j < 24; j++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3000));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3000)) * 32'($urandom_range(1, 4));
            run_job(ra, rb, $urandom_range(0, TIMEOUT + 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
